spi_temp_reader: RTL
====================

SPI_TEMP_READER -- requirements
Module: spi_temp_reader

Interface
REQ-001 The block SHALL have a parameter CLK_DIV, default 9: SCLK half-period in clk_in cycles, legal range 2..255; 9 gives 10 MHz SCLK from 180 MHz.
REQ-002 The block SHALL have a parameter DATA_BITS, default 16: bits per sensor read, legal range 8..32.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic SHALL use its rising edge.
REQ-004 The block SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port trig_in, input, 1 bit: sample-request square wave from the timer, synchronous to clk_in; every level change is one request.
REQ-006 The block SHALL have port spi_miso_in, input, 1 bit: sensor serial data, asynchronous to clk_in.
REQ-007 The block SHALL have port spi_sclk_out, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-008 The block SHALL have port spi_cs_n_out, output, 1 bit: active-low sensor chip select.
REQ-009 The block SHALL have port temp_out, output, DATA_BITS bits: last completed reading, MSB first on the wire.
REQ-010 The block SHALL have port temp_valid_out, output, 1 bit: one-cycle pulse when temp_out updates.
REQ-011 The block SHALL have port busy_out, output, 1 bit: high from CS_SETUP through DONE inclusive.

Function
REQ-012 trig_in SHALL be registered into trig_q each cycle; a request SHALL be the condition trig_in != trig_q.
REQ-013 spi_miso_in SHALL pass through a 2-flop synchronizer before use.
REQ-014 The FSM SHALL have states IDLE, CS_SETUP, SHIFT, CS_HOLD and DONE.
REQ-015 In IDLE, a request SHALL cause a transition to CS_SETUP on the next edge, and spi_cs_n_out SHALL go low in that same cycle.
REQ-016 CS_SETUP SHALL last CLK_DIV cycles with spi_sclk_out low.
REQ-017 SHIFT SHALL produce DATA_BITS SCLK periods, each CLK_DIV cycles low followed by CLK_DIV cycles high.
REQ-018 On each low-to-high SCLK transition, the synchronized MISO value SHALL be shifted into the LSB of the shift register.
REQ-019 CS_HOLD SHALL last CLK_DIV cycles with spi_sclk_out low and spi_cs_n_out low; spi_cs_n_out SHALL go high on entry to DONE.
REQ-020 DONE SHALL last 1 cycle, load temp_out from the shift register, pulse temp_valid_out, and return to IDLE.
REQ-021 temp_valid_out SHALL assert exactly LAT = 2*CLK_DIV*(DATA_BITS+1)+2 cycles after the cycle in which the request is detected (308 at defaults).
REQ-022 Requests detected in any state other than IDLE SHALL be ignored and not queued.
REQ-023 A request detected in the DONE cycle SHALL be ignored.
REQ-024 temp_out SHALL hold its value between completions.
REQ-025 spi_sclk_out SHALL never toggle while spi_cs_n_out is high.

Reset
REQ-026 Assertion of rst_n_in SHALL immediately force, even mid-transaction: spi_sclk_out=0, spi_cs_n_out=1, temp_out=0, temp_valid_out=0, busy_out=0, FSM=IDLE, trig_q=0, synchronizer=0, and all counters=0.
REQ-027 If trig_in is 1 at reset release, this SHALL be a request on the first clock after release.

Configuration
REQ-028 With TEMP_OVERRUN_DET_EN defined, the block SHALL provide an output port overrun_out (1 bit, reset 0) that sets sticky on any request ignored per REQ-022/REQ-023 and is cleared only by reset.
REQ-029 Without TEMP_OVERRUN_DET_EN, the port overrun_out and its logic SHALL be absent.

Structure
REQ-030 Package spi_temp_pkg SHALL hold the FSM state enum, DEF_CLK_DIV=9 and DEF_DATA_BITS=16.
REQ-031 A sub-module sclk_divider SHALL hold the half-period counter; it SHALL output a half-period tick and the SCLK level, and be enabled only in SHIFT.

Verification
REQ-032 Defaults; sensor model returns 16'hA5C3; single trig_in 0->1 -> cs_n low for 306 cycles, 16 SCLK pulses of 18 cycles each, temp_out=16'hA5C3, valid pulse 308 cycles after the edge.
REQ-033 Back-to-back reads 16'h0000 then 16'hFFFF on trig_in 0->1->0 spaced 400 cycles apart -> two valid pulses, values exact, temp_out held between pulses.
REQ-034 trig_in toggles 100 cycles into a transaction -> no second transaction; overrun_out=1 with the macro, port absent without it.
REQ-035 Reset asserted mid-SHIFT -> same-cycle cs_n=1, sclk=0, temp_out=0; the next request performs a clean full read.
REQ-036 CLK_DIV=2, DATA_BITS=8, reading 8'h81 -> 4-cycle SCLK period, temp_out=8'h81, LAT=38.
REQ-037 trig_in=1 held through reset release -> one transaction starts on the first post-reset cycle.

Source files
------------

// File: rtl/spi_temp_pkg.sv
// rtl/spi_temp_pkg.sv - shared state encoding and default parameters for spi_temp_reader
package spi_temp_pkg;

    localparam int DEF_CLK_DIV   = 9;
    localparam int DEF_DATA_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sclk_divider.sv
// rtl/sclk_divider.sv - SCLK half-period counter; level held low whenever disabled
module sclk_divider
    import spi_temp_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic en,
    output logic tick,
    output logic sclk
);

    logic [7:0] cnt;

    // tick marks the last clk_in cycle of the current half-period
    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= 8'd0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= 8'd0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_temp_reader.sv
// rtl/spi_temp_reader.sv - SPI mode-0 temperature sensor reader; TEMP_OVERRUN_DET_EN adds sticky overrun_out
module spi_temp_reader
    import spi_temp_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 trig_in,
    input  logic                 spi_miso_in,
    output logic                 spi_sclk_out,
    output logic                 spi_cs_n_out,
    output logic [DATA_BITS-1:0] temp_out,
    output logic                 temp_valid_out,
`ifdef TEMP_OVERRUN_DET_EN
    output logic                 overrun_out,
`endif
    output logic                 busy_out
);

    state_t               state;
    state_t               state_nxt;
    logic                 trig_q;
    logic                 req;
    logic [1:0]           miso_sync;
    logic [7:0]           cnt;
    logic [5:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick;
    logic                 sclk;
    logic                 div_en;
    logic                 cnt_done;
    logic                 last_bit;

    assign req          = (trig_in != trig_q);
    assign div_en       = (state == SHIFT);
    assign cnt_done     = (cnt == 8'(CLK_DIV - 1));
    assign last_bit     = (bit_cnt == 6'(DATA_BITS - 1));
    assign spi_sclk_out = sclk;

    sclk_divider #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_divider (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .en      (div_en),
        .tick    (tick),
        .sclk    (sclk)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req) state_nxt = CS_SETUP;
            CS_SETUP: if (cnt_done) state_nxt = SHIFT;
            // a bit period ends on the falling tick of its high phase
            SHIFT:    if (tick && sclk && last_bit) state_nxt = CS_HOLD;
            CS_HOLD:  if (cnt_done) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            trig_q         <= 1'b0;
            miso_sync      <= 2'b00;
            cnt            <= 8'd0;
            bit_cnt        <= 6'd0;
            shreg          <= '0;
            temp_out       <= '0;
            temp_valid_out <= 1'b0;
            busy_out       <= 1'b0;
            spi_cs_n_out   <= 1'b1;
        end else begin
            trig_q    <= trig_in;
            miso_sync <= {miso_sync[0], spi_miso_in};

            if ((state_nxt == state) && ((state == CS_SETUP) || (state == CS_HOLD))) begin
                cnt <= cnt + 8'd1;
            end else begin
                cnt <= 8'd0;
            end

            if (state != SHIFT) begin
                bit_cnt <= 6'd0;
            end else if (tick && sclk) begin
                bit_cnt <= bit_cnt + 6'd1;
            end

            // sample on the tick that raises SCLK
            if (div_en && tick && !sclk) begin
                shreg <= {shreg[DATA_BITS-2:0], miso_sync[1]};
            end

            // outputs follow the state being entered so CS and busy change on the transition edge
            spi_cs_n_out <= !((state_nxt == CS_SETUP) || (state_nxt == SHIFT) || (state_nxt == CS_HOLD));
            busy_out     <= (state_nxt != IDLE);

            temp_valid_out <= (state == DONE);
            if (state == DONE) begin
                temp_out <= shreg;
            end
        end
    end

`ifdef TEMP_OVERRUN_DET_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overrun_out <= 1'b0;
        end else if (req && (state != IDLE)) begin
            overrun_out <= 1'b1;
        end
    end
`endif

endmodule
